// File: rtl/sht40_meas_sequencer_if.sv
// Request/response bus between the SHT40 measurement sequencer (master modport)
// and i2c_master (slave modport).
interface sht40_meas_sequencer_if;
  logic        Processor_Ready;
  logic        i2c_writes;
  logic [6:0]  Peripheral_Address;
  logic [7:0]  Command_Data_Frames;
  logic        Master_Done;
  logic        CRC_Error;
  logic [15:0] Temperature_In;
  logic [15:0] Humidity_In;

  modport master (
    output Processor_Ready,
    output i2c_writes,
    output Peripheral_Address,
    output Command_Data_Frames,
    input  Master_Done,
    input  CRC_Error,
    input  Temperature_In,
    input  Humidity_In
  );

  modport slave (
    input  Processor_Ready,
    input  i2c_writes,
    input  Peripheral_Address,
    input  Command_Data_Frames,
    output Master_Done,
    output CRC_Error,
    output Temperature_In,
    output Humidity_In
  );
endinterface

// File: rtl/sht40_meas_sequencer.sv
// SHT40 measurement sequencer: measure-command write, conversion wait, 6-byte read,
// CRC-driven retry, single-shot/periodic sampling. Optional macro: SHT40_SOFT_RESET_EN.
module sht40_meas_sequencer #(
  parameter logic [6:0]  SENSOR_ADDR      = 7'h44,
  parameter int unsigned MEAS_WAIT_CYCLES = 20000,
  parameter int unsigned INTERVAL_CYCLES  = 100000,
  parameter int unsigned TIMEOUT_CYCLES   = 50000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Periodic_En,
  input  logic [1:0]  Precision_Sel,
  sht40_meas_sequencer_if.master i2c,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Sample_Valid,
  output logic        Busy,
  output logic        Error_Flag,
  output logic [1:0]  Retry_Count
);

  localparam int unsigned MAX_A = (MEAS_WAIT_CYCLES > INTERVAL_CYCLES) ? MEAS_WAIT_CYCLES
                                                                         : INTERVAL_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  // CONV length chosen so the read request rises MEAS_WAIT_CYCLES after the write Done cycle
  localparam int unsigned CONV_LAST = (MEAS_WAIT_CYCLES > 3) ? MEAS_WAIT_CYCLES - 3 : 0;
  localparam int unsigned INT_LAST  = (INTERVAL_CYCLES > 1) ? INTERVAL_CYCLES - 1 : 0;
  localparam int unsigned TMO_LAST  = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);
`ifdef SHT40_SOFT_RESET_EN
  localparam int unsigned SR_CYC  = MEAS_WAIT_CYCLES / 20;
  localparam int unsigned SR_LAST = (SR_CYC > 1) ? SR_CYC - 1 : 0;
`endif

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_WAIT, CONV, RD_REQ, RD_WAIT, CHECK, INTERVAL, SR_REQ, SR_WAIT
  } state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_writes;
  logic [7:0]       r_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  logic             r_err;
  logic             r_busy;
  logic             r_valid;
  logic             r_crc;
  logic             r_per_q;
  logic [15:0]      r_t_stage;
  logic [15:0]      r_h_stage;
  logic [15:0]      r_t_out;
  logic [15:0]      r_h_out;
`ifdef SHT40_SOFT_RESET_EN
  logic             r_sr_dly;
  logic             r_sr_err;
`endif

  logic             w_per_rise;
  logic             w_start;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_per_rise = Periodic_En & ~r_per_q;
  assign w_start    = Start | w_per_rise;
  assign w_cnt_inc  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  function automatic logic [7:0] prec_cmd(input logic [1:0] sel);
    case (sel)
      2'd0:    prec_cmd = 8'hFD;
      2'd1:    prec_cmd = 8'hF6;
      default: prec_cmd = 8'hE0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
`ifdef SHT40_SOFT_RESET_EN
      r_state  <= SR_REQ;
      r_sr_dly <= 1'b0;
      r_sr_err <= 1'b0;
`else
      r_state  <= IDLE;
`endif
      r_ready   <= 1'b0;
      r_writes  <= 1'b1;
      r_cmd     <= 8'hFD;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_crc     <= 1'b0;
      r_per_q   <= 1'b0;
      r_t_stage <= '0;
      r_h_stage <= '0;
      r_t_out   <= '0;
      r_h_out   <= '0;
    end else begin
      r_per_q <= Periodic_En;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cmd   <= prec_cmd(Precision_Sel);
            r_retry <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= WR_REQ;
          end
        end
        WR_REQ: begin
          r_ready  <= 1'b1;
          r_writes <= 1'b1;
          r_cnt    <= '0;
          r_state  <= WR_WAIT;
        end
        WR_WAIT: begin
          if (i2c.Master_Done) begin
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_state <= CONV;
          end else if (r_cnt >= CNT_W'(TMO_LAST)) begin
            // a timeout is scored as a failed attempt and goes through CHECK
            r_ready <= 1'b0;
            r_crc   <= 1'b1;
            r_state <= CHECK;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        CONV: begin
          if (r_cnt >= CNT_W'(CONV_LAST)) r_state <= RD_REQ;
          else                            r_cnt   <= w_cnt_inc;
        end
        RD_REQ: begin
          r_ready  <= 1'b1;
          r_writes <= 1'b0;
          r_cnt    <= '0;
          r_state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (i2c.Master_Done) begin
            r_ready   <= 1'b0;
            r_crc     <= i2c.CRC_Error;
            r_t_stage <= i2c.Temperature_In;
            r_h_stage <= i2c.Humidity_In;
            r_state   <= CHECK;
          end else if (r_cnt >= CNT_W'(TMO_LAST)) begin
            r_ready <= 1'b0;
            r_crc   <= 1'b1;
            r_state <= CHECK;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        CHECK: begin
          if (!r_crc) begin
            r_t_out <= r_t_stage;
            r_h_out <= r_h_stage;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= Periodic_En ? INTERVAL : IDLE;
          end else if (r_retry < RETRY_MAX) begin
            r_retry <= r_retry + 2'd1;
            r_crc   <= 1'b0;
            r_state <= WR_REQ;
          end else begin
            r_crc   <= 1'b0;
`ifdef SHT40_SOFT_RESET_EN
            r_sr_err <= 1'b1;
            r_state  <= SR_REQ;
`else
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`endif
          end
        end
        INTERVAL: begin
          if (!Periodic_En) begin
            r_state <= IDLE;
          end else if (Start || r_cnt >= CNT_W'(INT_LAST)) begin
            r_cmd   <= prec_cmd(Precision_Sel);
            r_retry <= '0;
            r_busy  <= 1'b1;
            r_state <= WR_REQ;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
`ifdef SHT40_SOFT_RESET_EN
        SR_REQ: begin
          r_ready  <= 1'b1;
          r_writes <= 1'b1;
          r_cmd    <= 8'h94;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
          r_sr_dly <= 1'b0;
          r_state  <= SR_WAIT;
        end
        SR_WAIT: begin
          // first wait for the write to finish, then hold off for the sensor reset time
          if (!r_sr_dly) begin
            if (i2c.Master_Done || r_cnt >= CNT_W'(TMO_LAST)) begin
              r_ready  <= 1'b0;
              r_cnt    <= '0;
              r_sr_dly <= 1'b1;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (r_cnt >= CNT_W'(SR_LAST)) begin
            r_err    <= r_sr_err;
            r_sr_err <= 1'b0;
            r_sr_dly <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
`endif
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign i2c.Processor_Ready     = r_ready;
  assign i2c.i2c_writes          = r_writes;
  assign i2c.Peripheral_Address  = SENSOR_ADDR;
  assign i2c.Command_Data_Frames = r_cmd;

  assign Temperature_Output = r_t_out;
  assign Humidity_Output    = r_h_out;
  assign Sample_Valid       = r_valid;
  assign Busy               = r_busy;
  assign Error_Flag         = r_err;
  assign Retry_Count        = r_retry;

endmodule
